// File: rtl/coin_pkg.sv
// Shared types and 50 MHz defaults for the coin-slot front end.
// One-hot FSM encoding used by coin_key_filter.
package coin_pkg;

    typedef enum logic [4:0] {
        IDLE        = 5'b00001,
        PRESS_DEB   = 5'b00010,
        PRESSED     = 5'b00100,
        RELEASE_DEB = 5'b01000,
        STUCK       = 5'b10000
    } state_e;

    // 20 ms debounce and 2 s jam limit at 50 MHz, both minus one
    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam logic [26:0] HOLD_MAX_DEF = 27'd99_999_999;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// INIT sets the value both flops take during reset.
module sync_2ff #(
    parameter int   WIDTH = 1,
    parameter logic INIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= {WIDTH{INIT}};
            q  <= {WIDTH{INIT}};
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/coin_key_filter.sv
// Coin-slot switch front end: synchronise, debounce, one pulse per coin,
// and jam detection so a stuck switch never yields repeated coins.
module coin_key_filter #(
    parameter logic [19:0] CNT_MAX  = coin_pkg::CNT_MAX_DEF,
    parameter logic [26:0] HOLD_MAX = coin_pkg::HOLD_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic po_money,
    output logic key_level,
    output logic stuck_err
);

    import coin_pkg::*;

    logic        key_s;
    state_e      state;
    logic [19:0] deb_cnt;
    logic [26:0] hold_cnt;

    sync_2ff #(
        .WIDTH (1),
        .INIT  (1'b1)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            po_money  <= 1'b0;
            key_level <= 1'b0;
            stuck_err <= 1'b0;
        end else begin
            po_money <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state    <= PRESS_DEB;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                    end
                end
                PRESS_DEB: begin
                    if (key_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == CNT_MAX) begin
                        state     <= PRESSED;
                        deb_cnt   <= '0;
                        po_money  <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 20'd1;
                    end
                end
                PRESSED: begin
                    // jam check wins over release
                    if (hold_cnt == HOLD_MAX) begin
                        state     <= STUCK;
                        deb_cnt   <= '0;
                        stuck_err <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 27'd1;
                        if (key_s) begin
                            state   <= RELEASE_DEB;
                            deb_cnt <= '0;
                        end
                    end
                end
                RELEASE_DEB: begin
                    // hold keeps running so a bouncing jam is still caught
                    if (hold_cnt == HOLD_MAX) begin
                        state     <= STUCK;
                        deb_cnt   <= '0;
                        stuck_err <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 27'd1;
                        if (!key_s) begin
                            state   <= PRESSED;
                            deb_cnt <= '0;
                        end else if (deb_cnt == CNT_MAX) begin
                            state     <= IDLE;
                            deb_cnt   <= '0;
                            key_level <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + 20'd1;
                        end
                    end
                end
                STUCK: begin
                    if (!key_s) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == CNT_MAX) begin
                        state     <= IDLE;
                        deb_cnt   <= '0;
                        key_level <= 1'b0;
                        stuck_err <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 20'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    deb_cnt   <= '0;
                    hold_cnt  <= '0;
                    po_money  <= 1'b0;
                    key_level <= 1'b0;
                    stuck_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_key_filter.sv
// Directed bench for coin_key_filter with CNT_MAX=4, HOLD_MAX=20.
// Expected pulse cycles are queued at stimulus time; a monitor pops them.
module tb_coin_key_filter;

    logic sys_clk;
    logic sys_rst_n;
    logic key_in;
    logic po_money;
    logic key_level;
    logic stuck_err;

    int tests;
    int failed;
    int cyc;
    int pulses;
    int falls;
    logic lvl_prev;
    int exp_q[$];

    coin_key_filter #(
        .CNT_MAX  (20'd4),
        .HOLD_MAX (27'd20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .po_money  (po_money),
        .key_level (key_level),
        .stuck_err (stuck_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // key_in held at v across n sampling edges; called and returns at a negedge
    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    // press whose edge 0 is the next posedge: pulse visible at cyc+8
    task automatic expect_pulse();
        exp_q.push_back(cyc + 8);
    endtask

    // monitor: pops the expected cycle whenever the DUT pulses
    always @(negedge sys_clk) begin
        if (po_money) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                check("pulse_cycle", cyc, exp_q.pop_front());
            end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0]) begin
            check("missing_pulse", cyc, exp_q.pop_front());
        end
        if (lvl_prev && !key_level) falls++;
        lvl_prev = key_level;
    end

    int p0;
    int f0;

    initial begin
        tests = 0;
        failed = 0;
        cyc = 0;
        pulses = 0;
        falls = 0;
        lvl_prev = 1'b0;
        key_in = 1'b1;
        sys_rst_n = 1'b0;

        repeat (3) @(negedge sys_clk);
        check("reset_po_money", int'(po_money), 0);
        check("reset_key_level", int'(key_level), 0);
        check("reset_stuck_err", int'(stuck_err), 0);
        sys_rst_n = 1'b1;
        hold(1'b1, 5);

        // 1: clean press and release
        expect_pulse();
        hold(1'b0, 7);
        check("t1_level_before", int'(key_level), 0);
        hold(1'b0, 1);
        check("t1_level_rise", int'(key_level), 1);
        hold(1'b0, 7);
        hold(1'b1, 7);
        check("t1_level_hold", int'(key_level), 1);
        hold(1'b1, 1);
        check("t1_level_fall", int'(key_level), 0);
        hold(1'b1, 10);

        // 2: press bounce, no pulse
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 12);
        check("t2_level", int'(key_level), 0);

        // 3: release bounce, one pulse and one fall
        f0 = falls;
        expect_pulse();
        hold(1'b0, 8);
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 12);
        check("t3_falls", falls - f0, 1);
        check("t3_level", int'(key_level), 0);

        // 4: jam held 40 cycles
        expect_pulse();
        hold(1'b0, 28);
        check("t4_stuck_before", int'(stuck_err), 0);
        check("t4_level_pressed", int'(key_level), 1);
        hold(1'b0, 1);
        check("t4_stuck_set", int'(stuck_err), 1);
        hold(1'b0, 11);
        hold(1'b1, 6);
        check("t4_stuck_held", int'(stuck_err), 1);
        check("t4_level_held", int'(key_level), 1);
        hold(1'b1, 1);
        check("t4_stuck_clear", int'(stuck_err), 0);
        check("t4_level_clear", int'(key_level), 0);
        hold(1'b1, 10);

        // 5: three back-to-back coins
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            expect_pulse();
            hold(1'b0, 8);
            hold(1'b1, 10);
        end
        check("t5_pulses", pulses - p0, 3);

        // 6: reset during PRESS_DEB with key held low
        hold(1'b0, 4);
        sys_rst_n = 1'b0;
        hold(1'b0, 3);
        check("t6_rst_po_money", int'(po_money), 0);
        check("t6_rst_key_level", int'(key_level), 0);
        check("t6_rst_stuck_err", int'(stuck_err), 0);
        sys_rst_n = 1'b1;
        expect_pulse();
        hold(1'b0, 10);
        check("t6_level", int'(key_level), 1);
        hold(1'b1, 15);

        check("total_pulses", pulses, 7);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
